// File: rtl/eprisc_mem_arbiter_pkg.sv
// Shared constants for the EP-RISC test-RAM arbiter: default widths,
// port indices and the ownership state encoding.
package eprisc_mem_arbiter_pkg;

   localparam int ADDR_W_DEF   = 12;
   localparam int DATA_W_DEF   = 32;
   localparam int MAX_LOCK_DEF = 16;

   // Port indices double as bit positions in the two-bit request/grant vectors
   localparam logic PORT_A = 1'b0;
   localparam logic PORT_B = 1'b1;

   typedef enum logic [1:0] {
      ST_FREE  = 2'd0,
      ST_OWN_A = 2'd1,
      ST_OWN_B = 2'd2
   } arbState_t;

endpackage

// File: rtl/eprisc_rr_pick2.sv
// Two-input round-robin picker: a lone request wins outright, and on
// contention the port that did not win last time gets the grant.
module eprisc_rr_pick2
   import eprisc_mem_arbiter_pkg::*;
(
   input  logic [1:0] iReq,
   input  logic       iLast,
   output logic [1:0] oGnt
);

   always_comb begin
      oGnt = iReq;
      if (iReq == 2'b11) begin
         oGnt = (iLast == PORT_B) ? 2'b01 : 2'b10;
      end
   end

endmodule

// File: rtl/eprisc_mem_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous RAM between a CPU
// port (A) and a debug/DMA port (B), with bounded bus locking.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_FREE  | no owner; round-robin picker decides between A and B
//   ST_OWN_A | A holds a lock; only A may be granted, B stalls
//   ST_OWN_B | B holds a lock; only B may be granted, A stalls
module eprisc_mem_arbiter
   import eprisc_mem_arbiter_pkg::*;
#(
   parameter int ADDR_W   = ADDR_W_DEF,
   parameter int DATA_W   = DATA_W_DEF,
   parameter int MAX_LOCK = MAX_LOCK_DEF
) (
   input  logic              iClk,
   input  logic              iReset,

   input  logic              iReqA,
   input  logic              iWrA,
   input  logic              iLockA,
   input  logic [ADDR_W-1:0] iAddrA,
   input  logic [DATA_W-1:0] iDataA,
   output logic              oGntA,
   output logic              oRdValidA,
   output logic [DATA_W-1:0] oRdDataA,

   input  logic              iReqB,
   input  logic              iWrB,
   input  logic              iLockB,
   input  logic [ADDR_W-1:0] iAddrB,
   input  logic [DATA_W-1:0] iDataB,
   output logic              oGntB,
   output logic              oRdValidB,
   output logic [DATA_W-1:0] oRdDataB,

   output logic [ADDR_W-1:0] oMemAddr,
   output logic [DATA_W-1:0] oMemData,
   output logic              oMemWrite,
   input  logic [DATA_W-1:0] iMemData
);

   localparam int CNT_W = $clog2(MAX_LOCK + 1);
   localparam logic [CNT_W-1:0] LOCK_LIMIT = CNT_W'(MAX_LOCK);

   arbState_t        rState;
   logic             rLast;
   logic [CNT_W-1:0] rLockCnt;
   logic             rRdValidA;
   logic             rRdValidB;

   logic [1:0]       pickGnt;
   logic             gntA;
   logic             gntB;
   logic [CNT_W-1:0] lockNext;
   logic             lockDone;

   eprisc_rr_pick2 uPick (
      .iReq  ({iReqB, iReqA}),
      .iLast (rLast),
      .oGnt  (pickGnt)
   );

   always_comb begin
      gntA = 1'b0;
      gntB = 1'b0;
      case (rState)
         ST_OWN_A: gntA = iReqA;
         ST_OWN_B: gntB = iReqB;
         default: begin
            gntA = pickGnt[PORT_A];
            gntB = pickGnt[PORT_B];
         end
      endcase
   end

   // Count saturates at the limit because reaching it always releases the bus
   assign lockNext = rLockCnt + CNT_W'(1);
   assign lockDone = (lockNext == LOCK_LIMIT);

   always_ff @(posedge iClk or posedge iReset) begin
      if (iReset) begin
         rState    <= ST_FREE;
         rLast     <= PORT_B;
         rLockCnt  <= '0;
         rRdValidA <= 1'b0;
         rRdValidB <= 1'b0;
      end else begin
         rRdValidA <= gntA & ~iWrA;
         rRdValidB <= gntB & ~iWrB;
         case (rState)
            ST_OWN_A: begin
               if (!iReqA || !iLockA || lockDone) begin
                  rState   <= ST_FREE;
                  rLast    <= PORT_A;
                  rLockCnt <= '0;
               end else begin
                  rLockCnt <= lockNext;
               end
            end
            ST_OWN_B: begin
               if (!iReqB || !iLockB || lockDone) begin
                  rState   <= ST_FREE;
                  rLast    <= PORT_B;
                  rLockCnt <= '0;
               end else begin
                  rLockCnt <= lockNext;
               end
            end
            default: begin
               if (gntA) begin
                  rLast <= PORT_A;
                  if (iLockA) begin
                     rState   <= ST_OWN_A;
                     rLockCnt <= CNT_W'(1);
                  end
               end else if (gntB) begin
                  rLast <= PORT_B;
                  if (iLockB) begin
                     rState   <= ST_OWN_B;
                     rLockCnt <= CNT_W'(1);
                  end
               end
            end
         endcase
      end
   end

   assign oGntA     = gntA;
   assign oGntB     = gntB;
   assign oMemWrite = (gntA & iWrA) | (gntB & iWrB);
   assign oMemAddr  = gntA ? iAddrA : (gntB ? iAddrB : '0);
   assign oMemData  = gntA ? iDataA : (gntB ? iDataB : '0);

   assign oRdValidA = rRdValidA;
   assign oRdValidB = rRdValidB;
   assign oRdDataA  = iMemData;
   assign oRdDataB  = iMemData;

endmodule
